pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage Y86-64 core. Decides stall/bubble for the F/D/E/M/W pipeline registers.
- Owns the architectural condition-code register that the execute stage consumes.
- Sequences post-reset pipeline flush and the terminal halt on a non-AOK writeback status.
- Sits beside the stage registers. Stall/bubble outputs are combinational from stage-register contents plus this block's state.

Parameters:
CNT_W, 32, width of optional performance counters
RNONE, 4'hF, "no register" ID
STAT_AOK, 4'h1, normal status code

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
D_icode  in  4  icode in decode register
d_srcA  in  4  decode source A register ID
d_srcB  in  4  decode source B register ID
E_icode  in  4  icode in execute register
E_dstM  in  4  execute-stage memory destination
e_cnd  in  1  execute condition result
alu_zf  in  1  execute ALU zero flag
alu_sf  in  1  execute ALU sign flag
alu_of  in  1  execute ALU overflow flag
M_icode  in  4  icode in memory register
m_stat  in  4  memory-stage status
W_stat  in  4  writeback-register status
cc  out  3  condition codes {of,sf,zf} (bit0 zf, bit1 sf, bit2 of)
F_stall  out  1  hold fetch PC register
D_stall  out  1  hold decode register
D_bubble  out  1  load NOP into decode register
E_bubble  out  1  load NOP into execute register
M_bubble  out  1  load NOP into memory register
W_stall  out  1  hold writeback register
halted  out  1  core stopped
halt_stat  out  4  W_stat captured at halt

Behaviour:
- Reset (async, rst_n=0):
  - state=FLUSH; cc=3'b001 (ZF set); halted=0; halt_stat=STAT_AOK.
- Icodes: MRMOVQ=5, OPQ=6, JXX=7, RET=9, POPQ=B.
- Combinational terms:
  - load_use = (E_icode==5 || E_icode==B) && E_dstM!=RNONE && (E_dstM==d_srcA || E_dstM==d_srcB).
  - ret_pend = RET in any of D_icode, E_icode, M_icode.
  - mispred = E_icode==7 && !e_cnd.
  - exc_m = m_stat!=STAT_AOK; exc_w = W_stat!=STAT_AOK.
- State machine, three states, registered on rising clk:
  - FLUSH (one cycle after reset):
    - D_bubble=E_bubble=M_bubble=1; F_stall=D_stall=W_stall=0; no CC update.
    - Next state: RUN unconditionally.
  - RUN:
    - F_stall = load_use || ret_pend.
    - D_stall = load_use.
    - D_bubble = mispred || (ret_pend && !load_use).
    - E_bubble = mispred || load_use.
    - M_bubble = exc_m || exc_w.
    - W_stall = exc_w.
    - Next state: HALTED when exc_w; otherwise RUN.
  - HALTED:
    - F_stall=D_stall=W_stall=1; all bubbles 0; halted=1.
    - Sticky until rst_n.
- Halt capture: on the RUN->HALTED edge, halt_stat <= W_stat, halted <= 1 (registered, 1-cycle latency).
- CC update: cc <= {alu_of,alu_sf,alu_zf} on a clk edge only when state==RUN && E_icode==OPQ && !exc_m && !exc_w. Otherwise cc holds.
  - The new cc is visible to the instruction in E the cycle after the OPq.
- Simultaneous events:
  - load_use and mispred both set: mispred wins for D. D_bubble=1 with D_stall=1 is illegal and never produced; force D_stall=0 when mispred.
  - F_stall still follows load_use || ret_pend.
  - ret_pend with mispred: D_bubble=1, F_stall=1.
  - exc_w in the same cycle as OPq in E: no CC update; transition to HALTED.
- Reset mid-operation: all state and cc return to reset values immediately; FLUSH is re-run.
- No output ever X after reset. Unknown icodes are treated as no-hazard.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: adds outputs stall_cnt, bubble_cnt, mispred_cnt, each CNT_W bits.
  - Async reset to 0.
  - stall_cnt increments each RUN cycle with F_stall=1.
  - bubble_cnt increments each RUN cycle with E_bubble=1.
  - mispred_cnt increments each RUN cycle with mispred=1.
  - All counters saturate at all-ones; all freeze in HALTED.
- Undefined: ports and logic absent; otherwise identical behaviour.

Test Plan:
- Reset release, all icodes=NOP (1), stats=1 -> cycle 0: D/E/M_bubble=1. Cycle 1: all controls 0, cc=3'b001, halted=0.
- E_icode=5, E_dstM=3, d_srcB=3, RUN -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. With E_dstM=F -> all 0.
- D_icode=9 -> F_stall=1, D_bubble=1. Then move to E_icode=9, then M_icode=9 -> same for each. Then all NOP -> all 0.
- E_icode=7, e_cnd=0, plus load_use active -> D_bubble=1, E_bubble=1, D_stall=0. With e_cnd=1 -> no bubbles.
- E_icode=6, alu_zf=0, alu_sf=1, alu_of=1 -> next cycle cc=3'b110. Repeat with m_stat=3 -> cc unchanged, M_bubble=1.
- W_stat=2 -> W_stall=1 same cycle. Next cycle: halted=1, halt_stat=2, F/D/W_stall=1. Then rst_n pulse low mid-halt -> FLUSH, halted=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline control: stall/bubble decisions, CC register, flush and halt sequencing.
// Optional performance counters are enabled with the PIPE_PERF_CNT_EN macro.
module pipe_hazard_ctrl #(
    parameter int         CNT_W    = 32,
    parameter logic [3:0] RNONE    = 4'hF,
    parameter logic [3:0] STAT_AOK = 4'h1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_cnd,
    input  logic             alu_zf,
    input  logic             alu_sf,
    input  logic             alu_of,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    output logic [2:0]       cc,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             halted,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
`endif
    output logic [3:0]       halt_stat
);

    // state  | meaning
    // FLUSH  | first cycle after reset, bubble D/E/M to clear stage registers
    // RUN    | normal hazard resolution
    // HALTED | non-AOK status reached writeback; pipeline frozen until reset
    typedef enum logic [1:0] {
        FLUSH  = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    state_t state;

    logic load_use;
    logic ret_pend;
    logic mispred;
    logic exc_m;
    logic exc_w;
    logic cc_upd;

    assign load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != RNONE)
                      && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign ret_pend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mispred  = (E_icode == I_JXX) && !e_cnd;
    assign exc_m    = (m_stat != STAT_AOK);
    assign exc_w    = (W_stat != STAT_AOK);
    assign cc_upd   = (state == RUN) && (E_icode == I_OPQ) && !exc_m && !exc_w;

    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        case (state)
            FLUSH: begin
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
            end
            RUN: begin
                F_stall  = load_use || ret_pend;
                // a mispredicted branch squashes D, so holding it would be contradictory
                D_stall  = load_use && !mispred;
                D_bubble = mispred || (ret_pend && !load_use);
                E_bubble = mispred || load_use;
                M_bubble = exc_m || exc_w;
                W_stall  = exc_w;
            end
            HALTED: begin
                F_stall = 1'b1;
                D_stall = 1'b1;
                W_stall = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FLUSH;
            cc        <= 3'b001;
            halted    <= 1'b0;
            halt_stat <= STAT_AOK;
        end else begin
            if (cc_upd)
                cc <= {alu_of, alu_sf, alu_zf};
            case (state)
                FLUSH: state <= RUN;
                RUN: begin
                    if (exc_w) begin
                        state     <= HALTED;
                        halted    <= 1'b1;
                        halt_stat <= W_stat;
                    end
                end
                HALTED: state <= HALTED;
                default: state <= FLUSH;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt   <= '0;
            bubble_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (state == RUN) begin
            if (F_stall && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_ONE;
            if (E_bubble && (bubble_cnt != CNT_MAX))
                bubble_cnt <= bubble_cnt + CNT_ONE;
            if (mispred && (mispred_cnt != CNT_MAX))
                mispred_cnt <= mispred_cnt + CNT_ONE;
        end
    end
`endif

endmodule
